// File: rtl/cpu_io_port.sv
// cpu_io_port: per-channel strobe-captured input FIFOs, one-cycle CPU read port, latched outputs (optional CPU_IO_SYNC_EN input synchronisers)
module cpu_io_port #(
  parameter int WIDTH      = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] input_pin,
  input  logic [NUM_CH-1:0]       input_enable,
  input  logic [CH_W-1:0]         cpu_ch,
  input  logic                    cpu_rd,
  input  logic                    cpu_wr,
  input  logic [WIDTH-1:0]        cpu_wdata,
  input  logic                    cpu_clr,
  output logic [WIDTH-1:0]        cpu_rdata,
  output logic                    cpu_rvalid,
  output logic [NUM_CH*WIDTH-1:0] output_pin,
  output logic [NUM_CH-1:0]       in_empty,
  output logic [NUM_CH-1:0]       in_full,
  output logic [NUM_CH-1:0]       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [NUM_CH*WIDTH-1:0] pin_s;
  logic [NUM_CH-1:0] en_s, hist_q, push, pop, push_ok, sel;
  logic ch_ok;
  logic [NUM_CH-1:0][AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [NUM_CH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic rvalid_q, rvalid_d;
  logic [NUM_CH*WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mem_q [NUM_CH][FIFO_DEPTH];
`ifdef CPU_IO_SYNC_EN
  logic [NUM_CH*WIDTH-1:0] pin_m_q, pin_s_q;
  logic [NUM_CH-1:0] en_m_q, en_s_q;
  // two-flop synchroniser on every data and strobe bit, so data stays aligned with its strobe
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pin_m_q <= '0;
      pin_s_q <= '0;
      en_m_q  <= '0;
      en_s_q  <= '0;
    end else begin
      pin_m_q <= input_pin;
      pin_s_q <= pin_m_q;
      en_m_q  <= input_enable;
      en_s_q  <= en_m_q;
    end
  assign pin_s = pin_s_q;
  assign en_s  = en_s_q;
`else
  assign pin_s = input_pin;
  assign en_s  = input_enable;
`endif
  assign ch_ok      = int'(cpu_ch) < NUM_CH;
  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign output_pin = out_q;
  assign in_empty   = empty_q;
  assign in_full    = full_q;
  assign overflow   = ovf_q;
  // per-channel push/pop decisions; a pop frees the slot a simultaneous push needs, and overflow set beats clear
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    cnt_d = cnt_q;
    empty_d = empty_q;
    full_d = full_q;
    ovf_d = ovf_q;
    out_d = out_q;
    rdata_d = rdata_q;
    rvalid_d = 1'b0;
    sel = '0;
    push = '0;
    pop = '0;
    push_ok = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel[c] = ch_ok && cpu_ch == CH_W'(c);
      push[c] = en_s[c] && !hist_q[c];
      pop[c] = cpu_rd && sel[c] && !empty_q[c];
      push_ok[c] = push[c] && (!full_q[c] || pop[c]);
      wp_d[c] = push_ok[c] ? wp_q[c] + AW'(1) : wp_q[c];
      rp_d[c] = pop[c] ? rp_q[c] + AW'(1) : rp_q[c];
      cnt_d[c] = cnt_q[c] + CW'(push_ok[c]) - CW'(pop[c]);
      empty_d[c] = cnt_d[c] == '0;
      full_d[c] = cnt_d[c] == CW'(FIFO_DEPTH);
      ovf_d[c] = (push[c] && !push_ok[c]) ? 1'b1 : (cpu_clr && sel[c]) ? 1'b0 : ovf_q[c];
      out_d[c*WIDTH +: WIDTH] = (cpu_wr && sel[c]) ? cpu_wdata : out_q[c*WIDTH +: WIDTH];
      if (pop[c]) begin
        rdata_d = mem_q[c][rp_q[c]];
        rvalid_d = 1'b1;
      end
    end
  end
  // control and status state; async clear discards queued words by zeroing pointers and counts
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hist_q   <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      empty_q  <= '1;
      full_q   <= '0;
      ovf_q    <= '0;
      out_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      hist_q   <= en_s;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      out_q    <= out_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  // FIFO storage needs no reset: entries are only visible between the pointers
  always_ff @(posedge clk)
    for (int c = 0; c < NUM_CH; c++)
      if (push_ok[c]) mem_q[c][wp_q[c]] <= pin_s[c*WIDTH +: WIDTH];
endmodule

// File: tb/tb_cpu_io_port.sv
// tb_cpu_io_port: directed plus random stimulus against a queue-based reference model
module tb_cpu_io_port;
  localparam int W  = 16;
  localparam int NC = 3;
  localparam int D  = 4;
  localparam int PW = NC * W;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [PW-1:0] input_pin = '0;
  logic [NC-1:0] input_enable = '0;
  logic [1:0] cpu_ch = '0;
  logic cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_clr = 1'b0;
  logic [W-1:0] cpu_wdata = '0;
  logic [W-1:0] cpu_rdata;
  logic cpu_rvalid;
  logic [PW-1:0] output_pin;
  logic [NC-1:0] in_empty, in_full, overflow;
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] mq [NC][$];
  logic [NC-1:0] m_hist, m_ovf;
  logic [PW-1:0] m_out;
  logic [W-1:0] m_rdata;
  logic m_rvalid;

  cpu_io_port #(.WIDTH(W), .NUM_CH(NC), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .input_pin(input_pin), .input_enable(input_enable),
    .cpu_ch(cpu_ch), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_clr(cpu_clr),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .output_pin(output_pin),
    .in_empty(in_empty), .in_full(in_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) mq[c].delete();
    m_hist = '0;
    m_ovf = '0;
    m_out = '0;
    m_rdata = '0;
    m_rvalid = 1'b0;
  endtask

  task automatic model_edge();
    logic [NC-1:0] rise;
    rise = input_enable & ~m_hist;
    m_rvalid = 1'b0;
    if (cpu_ch < NC) begin
      if (cpu_clr) m_ovf[cpu_ch] = 1'b0;
      if (cpu_wr) m_out[cpu_ch*W +: W] = cpu_wdata;
      if (cpu_rd && mq[cpu_ch].size() > 0) begin
        m_rdata = mq[cpu_ch].pop_front();
        m_rvalid = 1'b1;
      end
    end
    for (int c = 0; c < NC; c++)
      if (rise[c]) begin
        if (mq[c].size() < D) mq[c].push_back(input_pin[c*W +: W]);
        else m_ovf[c] = 1'b1;
      end
    m_hist = input_enable;
  endtask

  task automatic compare_all(input string tag);
    logic [NC-1:0] e, f;
    for (int c = 0; c < NC; c++) begin
      e[c] = mq[c].size() == 0;
      f[c] = mq[c].size() == D;
    end
    check({tag, ".rdata"}, cpu_rdata, m_rdata);
    check({tag, ".rvalid"}, cpu_rvalid, m_rvalid);
    check({tag, ".out"}, output_pin, m_out);
    check({tag, ".empty"}, in_empty, e);
    check({tag, ".full"}, in_full, f);
    check({tag, ".ovf"}, overflow, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    compare_all("cyc");
  endtask

  task automatic cyc(input logic [NC-1:0] en, input logic rd, input logic [1:0] ch,
                     input logic wr, input logic [W-1:0] wd, input logic clr);
    input_enable = en;
    cpu_rd = rd;
    cpu_ch = ch;
    cpu_wr = wr;
    cpu_wdata = wd;
    cpu_clr = clr;
    step();
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    model_reset();
    #1 compare_all(tag);
  endtask

  initial begin
    #1 reset = 1'b0;
    model_reset();
    #2 compare_all("rst");
    step();
    reset = 1'b1;
    input_pin = PW'(16'hf0f0);
    cyc(3'b001, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
    check("t1.empty0", in_empty[0], 1'b0);
    cyc(3'b000, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
    cyc(3'b000, 1'b1, 2'd0, 1'b0, 16'h0, 1'b0);
    check("t1.rdata", cpu_rdata, 16'hf0f0);
    check("t1.rvalid", cpu_rvalid, 1'b1);
    check("t1.empty_after", in_empty[0], 1'b1);
    input_pin = PW'({16'h1234, 16'h0});
    repeat (10) cyc(3'b010, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
    cyc(3'b000, 1'b1, 2'd1, 1'b0, 16'h0, 1'b0);
    check("t2.rd1", cpu_rdata, 16'h1234);
    cyc(3'b000, 1'b1, 2'd1, 1'b0, 16'h0, 1'b0);
    check("t2.rd2_valid", cpu_rvalid, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      input_pin = PW'(i);
      cyc(3'b001, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
      cyc(3'b000, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
    end
    check("t3.full", in_full[0], 1'b1);
    check("t3.ovf", overflow[0], 1'b1);
    cyc(3'b000, 1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
    check("t3.clr", overflow[0], 1'b0);
    input_pin = PW'(9);
    cyc(3'b001, 1'b1, 2'd0, 1'b0, 16'h0, 1'b0);
    check("t3.fullpop_rdata", cpu_rdata, 16'd1);
    check("t3.fullpop_full", in_full[0], 1'b1);
    check("t3.fullpop_ovf", overflow[0], 1'b0);
    cyc(3'b000, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
    cyc(3'b001, 1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
    check("t3.set_wins", overflow[0], 1'b1);
    cyc(3'b000, 1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(3'b000, 1'b1, 2'd0, 1'b0, 16'h0, 1'b0);
    check("t3.last", cpu_rdata, 16'd9);
    cyc(3'b000, 1'b0, 2'd1, 1'b1, 16'hbeef, 1'b0);
    check("t4.hi", output_pin[31:16], 16'hbeef);
    check("t4.lo", output_pin[15:0], 16'h0);
    cyc(3'b000, 1'b0, 2'd3, 1'b1, 16'hdead, 1'b1);
    check("t4.badch", output_pin, PW'(32'hbeef_0000));
    for (int i = 0; i < 3; i++) begin
      input_pin = PW'({16'(i + 7), 32'h0});
      cyc(3'b100, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
      cyc(3'b000, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
    end
    cyc(3'b000, 1'b1, 2'd2, 1'b1, 16'h5a5a, 1'b0);
    check("t5.pre_rvalid", cpu_rvalid, 1'b1);
    input_enable = 3'b001;
    async_reset("t5.rst");
    check("t5.rvalid_cancel", cpu_rvalid, 1'b0);
    check("t5.empty", in_empty, 3'b111);
    step();
    reset = 1'b1;
    cyc(3'b001, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
    check("t5.hold_push", in_empty[0], 1'b0);
    for (int i = 0; i < 600; i++) begin
      input_pin = PW'({$urandom(), $urandom()});
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd.rst");
        step();
        reset = 1'b1;
      end
      cyc(NC'($urandom), $urandom_range(0, 3) == 0, 2'($urandom), $urandom_range(0, 4) == 0,
          W'($urandom), $urandom_range(0, 7) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
